max_pool2x2: RTL
================

// Module: max_pool2x2
// PURPOSE
//  Streaming 2x2/stride-2 max-pooling stage placed directly downstream of the
//  bias/ReLU writeback. Consumes finished post-ReLU pixels of one output channel
//  in row-major raster order and emits one pooled pixel per 2x2 window.
//  Keeps one row of horizontal maxima in an internal line buffer.
// PARAMETERS
//  pixel_bit  36   signed pixel width, in and out
//  IMG_W      224  input feature-map width; must be even
//  IMG_H      224  input feature-map height; must be even
//  ADDR_W     7    line-buffer address width; 2**ADDR_W >= IMG_W/2
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-high reset
//  frame_start  in   1          sync pulse: realign counters to row 0, col 0
//  in_valid     in   1          pixel_in valid this cycle
//  pixel_in     in   pixel_bit  signed post-ReLU pixel
//  out_valid    out  1          pixel_out valid (1-cycle pulse per window)
//  pixel_out    out  pixel_bit  signed pooled pixel
//  frame_done   out  1          pulses together with the last pooled pixel
// BEHAVIOUR
//  - No backpressure. Consumer always accepts. in_valid may be sparse.
//  - Reset: col_cnt, row_cnt, hold_reg, pixel_out = 0; out_valid, frame_done = 0.
//    The line buffer is not cleared. It is always written before it is read.
//  - Counters advance only on in_valid beats. col wraps IMG_W-1 -> 0 and
//    increments row. row wraps IMG_H-1 -> 0 (next frame starts automatically).
//  - Per in_valid beat:
//    col even: hold_reg <= pixel_in.
//    col odd:  h = max(hold_reg, pixel_in), using a signed compare.
//      row even: linebuf[col>>1] <= h; no output.
//      row odd:  pixel_out <= max(linebuf[col>>1], h); out_valid <= 1.
//  - Ties select either operand (values are equal). Width is unchanged; there is no
//    saturation. Negative inputs are handled correctly even though ReLU output is >= 0.
//  - Latency: out_valid rises exactly 1 clk after the in_valid beat at
//    (row odd, col odd). pixel_out holds its value until the next output.
//  - out_valid and frame_done are otherwise 0 and last one cycle.
//  - frame_done = 1 with the output for (row IMG_H-1, col IMG_W-1).
//  - frame_start (sync) clears col_cnt, row_cnt, and hold_reg.
//    With in_valid in the same cycle, that beat is pixel (0,0).
//    Mid-frame frame_start abandons the partial frame and emits no output for it.
//    It does not clear out_valid from an in-flight beat of the previous cycle.
//  - Async reset mid-frame aborts immediately. The next in_valid beat is pixel (0,0).
//  - Line-buffer read and write use the same index. In a row-even cycle only a write
//    occurs; in a row-odd cycle only a read occurs. There is no read/write collision.
//  - Output rate: IMG_W/2 * IMG_H/2 pulses per frame.
// TESTING (bench uses IMG_W=4, IMG_H=4, pixel_bit=36)
//  1. Stream 0..15 back-to-back.
//     -> out_valid pulses carry 5, 7, 13, 15; frame_done asserts with 15.
//  2. Same frame with in_valid toggling every other cycle.
//     -> identical values; each pulse comes 1 clk after beats 5, 7, 13, 15.
//  3. Window {-3,-7,-1,-9} (signed) in the top-left, other pixels -20.
//     -> first output = -1. This checks the signed compare.
//  4. Two frames back-to-back with no gap (0..15, then 100..115).
//     -> 5, 7, 13, 15, 105, 107, 113, 115; frame_done pulses twice.
//  5. Assert reset after 6 pixels, then send a full frame 0..15.
//     -> no output from the partial frame; next outputs are 5, 7, 13, 15.
//  6. Assert frame_start along with pixel 9 of a frame, then continue 9..24 as a new frame.
//     -> outputs are 14, 16, 22, 24.

Source files
------------

// File: rtl/max_pool2x2.sv
// Streaming 2x2 / stride-2 max-pooling stage for one channel of post-ReLU pixels in raster order.
// A line buffer holds the horizontal pair maxima of each even row until the odd row below arrives.
module max_pool2x2 #(
  parameter int pixel_bit = 36,
  parameter int IMG_W     = 224,
  parameter int IMG_H     = 224,
  parameter int ADDR_W    = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        in_valid,
  input  logic signed [pixel_bit-1:0] pixel_in,
  output logic                        out_valid,
  output logic signed [pixel_bit-1:0] pixel_out,
  output logic                        frame_done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  function automatic logic signed [pixel_bit-1:0] smax(
    input logic signed [pixel_bit-1:0] a,
    input logic signed [pixel_bit-1:0] b
  );
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [CW-1:0]               col_q, col_d, col_eff_s;
  logic [RW-1:0]               row_q, row_d, row_eff_s;
  logic signed [pixel_bit-1:0] hold_q, hold_d, hold_eff_s;
  logic signed [pixel_bit-1:0] pixel_out_q, pixel_out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        frame_done_q, frame_done_d;
  logic signed [pixel_bit-1:0] linebuf_q [2**ADDR_W];
  logic [ADDR_W-1:0]           lb_idx_s;
  logic                        lb_we_s;
  logic signed [pixel_bit-1:0] h_s;
  logic signed [pixel_bit-1:0] lb_rd_s;

  // frame_start realigns to (0,0) in the same cycle, so a coincident beat is the first pixel.
  always_comb begin
    if (frame_start) begin
      col_eff_s  = '0;
      row_eff_s  = '0;
      hold_eff_s = '0;
    end else begin
      col_eff_s  = col_q;
      row_eff_s  = row_q;
      hold_eff_s = hold_q;
    end
  end

  assign lb_idx_s = ADDR_W'(col_eff_s >> 1);
  assign lb_rd_s  = linebuf_q[lb_idx_s];
  assign h_s      = smax(hold_eff_s, pixel_in);

  // Next-state for counters, pair hold register and the registered output stage.
  always_comb begin
    col_d        = col_eff_s;
    row_d        = row_eff_s;
    hold_d       = hold_eff_s;
    pixel_out_d  = pixel_out_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we_s      = 1'b0;
    if (in_valid) begin
      if (!col_eff_s[0]) begin
        hold_d = pixel_in;
      end else if (!row_eff_s[0]) begin
        lb_we_s = 1'b1;
      end else begin
        pixel_out_d  = smax(lb_rd_s, h_s);
        out_valid_d  = 1'b1;
        frame_done_d = (row_eff_s == ROW_LAST) && (col_eff_s == COL_LAST);
      end
      if (col_eff_s == COL_LAST) begin
        col_d = '0;
        if (row_eff_s == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_eff_s + ROW_ONE;
        end
      end else begin
        col_d = col_eff_s + COL_ONE;
        row_d = row_eff_s;
      end
    end else begin
      lb_we_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      pixel_out_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      pixel_out_q  <= pixel_out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer is never cleared: every odd-row read follows an even-row write of the same slot.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      linebuf_q[lb_idx_s] <= h_s;
    end
  end

  assign out_valid  = out_valid_q;
  assign pixel_out  = pixel_out_q;
  assign frame_done = frame_done_q;

endmodule
